// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: datapath width, mult/div op encodings and the
// mult/div sequencer state encoding.
package mips16_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      MD_MULTU = 2'b00,
      MD_MULT  = 2'b01,
      MD_DIVU  = 2'b10,
      MD_DIV   = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } md_state_e;

   function automatic logic md_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/neg_cond.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module neg_cond #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? ({W{1'b0}} - a) : a;

endmodule

// File: rtl/mult_div16.sv
// Iterative 16-bit multiply/divide unit with private hi/lo registers.
// Works on magnitudes for 16 iterations, then fixes signs in one extra cycle.
//
// state | meaning
// IDLE  | waiting for start; done cycle also lives here
// CALC  | one shift-add (mult) or restoring-subtract (div) step per edge
// FIX   | apply result signs, write hi/lo, pulse done
module mult_div16 #(
   parameter int WIDTH = mips16_pkg::WIDTH,
   parameter int CNT_W = mips16_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divByZero
);
   import mips16_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [WIDTH-1:0]   rs_q, rs_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH-1:0]   rs_abs, rt_abs;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic               signed_op;

   assign signed_op = md_is_signed(op_q);

   neg_cond #(.W(WIDTH)) u_abs_rs (
      .a   (rs),
      .neg (md_is_signed(op) & rs[WIDTH-1]),
      .y   (rs_abs)
   );

   neg_cond #(.W(WIDTH)) u_abs_rt (
      .a   (rt),
      .neg (md_is_signed(op) & rt[WIDTH-1]),
      .y   (rt_abs)
   );

   neg_cond #(.W(2*WIDTH)) u_fix_prod (
      .a   (acc_q),
      .neg (signed_op & negq_q),
      .y   (prod_fix)
   );

   neg_cond #(.W(WIDTH)) u_fix_quo (
      .a   (acc_q[WIDTH-1:0]),
      .neg (signed_op & negq_q),
      .y   (quo_fix)
   );

   neg_cond #(.W(WIDTH)) u_fix_rem (
      .a   (acc_q[2*WIDTH-1:WIDTH]),
      .neg (signed_op & negr_q),
      .y   (rem_fix)
   );

   // Multiply: upper half accumulates, product shifts right one bit per step.
   // Divide: upper half is the partial remainder, lower half collects quotient.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  {1'b0, (s_q[0] ? m_q : {WIDTH{1'b0}})};
      div_trial = {acc_q[2*WIDTH-1:WIDTH], s_q[WIDTH-1]};
      div_ge    = (div_trial >= {1'b0, m_q});
      div_diff  = div_trial[WIDTH-1:0] - m_q;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      m_d     = m_q;
      s_d     = s_q;
      rs_d    = rs_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = md_op_e'(op);
               m_d     = md_is_div(op) ? rt_abs : rs_abs;
               s_d     = md_is_div(op) ? rs_abs : rt_abs;
               rs_d    = rs;
               negq_d  = rs[WIDTH-1] ^ rt[WIDTH-1];
               negr_d  = rs[WIDTH-1];
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end

         CALC: begin
            if (md_is_div(op_q)) begin
               acc_d = {(div_ge ? div_diff : div_trial[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
               s_d   = {s_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               s_d   = {1'b0, s_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (md_is_div(op_q) && (m_q == '0)) begin
               hi_d  = rs_q;
               lo_d  = {WIDTH{1'b1}};
               dbz_d = 1'b1;
            end else if (md_is_div(op_q)) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         op_q    <= MD_MULTU;
         m_q     <= '0;
         s_q     <= '0;
         rs_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         m_q     <= m_d;
         s_q     <= s_d;
         rs_q    <= rs_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign divByZero = dbz_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: doc/mult_div16.md
Name: mult_div16

Overview:
- Iterative multiply/divide unit for the 16-bit single-cycle MIPS datapath.
- Sits directly downstream of the 16-entry register file and consumes its rs/rt read ports.
- Implements mult/multu/div/divu into private hi/lo registers, which mfhi/mflo read later.
- The control unit stalls the PC while busy=1.

Parameters:
- WIDTH, 16, operand width; only 16 is verified.
- CNT_W, 4, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstN  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 multu, 01 mult, 10 divu, 11 div; latched with start.
- rs  input  WIDTH  register-file rs read data: multiplicand or dividend.
- rt  input  WIDTH  register-file rt read data: multiplier or divisor.
- busy  output  1  operation in flight; PC stall request.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle.
- hi  output  WIDTH  product[31:16] or remainder.
- lo  output  WIDTH  product[15:0] or quotient.
- divByZero  output  1  pulses with done when a div/divu had rt=0.

Behaviour:
- Reset (rstN=0, asynchronous) forces state IDLE, hi=lo=0, busy=0, done=0, divByZero=0, counter=0.
- Reset mid-operation aborts the operation; no partial result is ever written.
- States: IDLE -> CALC -> FIX -> IDLE.
- Accept edge k (start=1 and busy=0):
  - latch op;
  - latch |rs| and |rt|; absolute values are taken only for signed ops;
  - record negQ = sign(rs) XOR sign(rt);
  - record negR = sign(rs);
  - clear the 32-bit accumulator and counter;
  - go to CALC; busy=1 from this edge.
- CALC, edges k+1..k+16, one iteration per edge:
  - multiply: shift-add, one multiplier bit per cycle, LSB first;
  - divide: restoring, one quotient bit per cycle, MSB first;
  - the counter increments each edge; at count 15 go to FIX.
- FIX, edge k+17:
  - signed multiply: negate the 32-bit product if negQ;
  - signed divide: negate the quotient if negQ and the remainder if negR;
  - write hi/lo, pulse done=1 and busy=0, return to IDLE.
- Latency: done is high in the cycle after edge k+17, i.e. 17 cycles after acceptance.
- hi/lo hold their value until the next completed operation.
- start while busy=1 is ignored, with no queueing.
- start in the done cycle is accepted, so back-to-back operations are legal.
- Divide by zero (rt=0, div or divu):
  - full latency is preserved;
  - result hi=rs (original value), lo=16'hFFFF;
  - divByZero=1 for the done cycle.
- Signed overflow: 0x8000 / 0xFFFF gives lo=0x8000, hi=0x0000, with no flag.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- rs/rt are only sampled at acceptance; later register-file writes do not affect the operation in flight.

Decomposition:
- Shared package mips16_pkg holds:
  - op encodings MD_MULTU, MD_MULT, MD_DIVU, MD_DIV;
  - the state encoding (IDLE, CALC, FIX);
  - the WIDTH constant shared with the register file and ALU.
- One sub-module, neg_cond: a combinational conditional two's-complement negate, parameterised width.
- neg_cond is instantiated for:
  - operand abs (WIDTH);
  - product fix (2*WIDTH);
  - quotient and remainder fix (WIDTH).

Test Plan:
- multu, rs=0xFFFF, rt=0xFFFF -> hi=0xFFFE, lo=0x0001, done exactly 17 cycles after accept, busy high 17 cycles.
- mult, rs=0xFFFD (-3), rt=0x0005 -> hi=0xFFFF, lo=0xFFF1 (-15); mult with rs=0x7FFF, rt=0x7FFF -> hi=0x3FFF, lo=0x0001.
- div, rs=0xFFF9 (-7), rt=0x0002 -> lo=0xFFFD (-3), hi=0xFFFF (-1); divu with the same operands -> lo=0x7FFC, hi=0x0001.
- divu, rs=0x0064, rt=0x0000 -> lo=0xFFFF, hi=0x0064, divByZero=1 for one cycle; div with rs=0x8000, rt=0xFFFF -> lo=0x8000, hi=0x0000, divByZero=0.
- start pulsed at accept+5 with different operands -> ignored, result unchanged; start held in the done cycle -> second op accepted, its done 17 cycles later.
- rstN low at accept+8 -> busy, done, hi, lo become 0 immediately, no done pulse; the next start after release completes normally.
